// File: rtl/mux2_arbiter.sv
// Two-requester arbiter that owns the select line of a downstream 2:1 mux.
// Define ARB_TIMEOUT_EN to compile in the MAX_HOLD hold counter and forced handoff.
module mux2_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state, state_n;
  logic   ptr, ptr_n;
  logic   sel_n;
  logic   owner;
  state_t other;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold_cnt, hold_cnt_n;
  logic          timeout_n;
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner   = (state == OWN1);
    other   = owner ? OWN0 : OWN1;
`ifdef ARB_TIMEOUT_EN
    timeout_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        case (req)
          2'b01:   state_n = OWN0;
          2'b10:   state_n = OWN1;
          2'b11:   state_n = ptr ? OWN1 : OWN0;
          default: state_n = IDLE;
        endcase
      end
      OWN0, OWN1: begin
        // The owner's own req in its release cycle is not a new request.
        if (!req[owner] || last[owner]) begin
          ptr_n   = ~owner;
          state_n = req[~owner] ? other : IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if ((hold_cnt == CW'(MAX_HOLD)) && req[~owner]) begin
          state_n   = other;
          ptr_n     = owner;
          timeout_n = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase

    sel_n = sel;
    if (state_n == OWN0)      sel_n = 1'b0;
    else if (state_n == OWN1) sel_n = 1'b1;

`ifdef ARB_TIMEOUT_EN
    // Count the cycles of the current grant, restarting at 1 on any change.
    if (state_n == IDLE)                  hold_cnt_n = '0;
    else if (state_n != state)            hold_cnt_n = CW'(1);
    else if (hold_cnt != CW'(MAX_HOLD))   hold_cnt_n = hold_cnt + CW'(1);
    else                                  hold_cnt_n = hold_cnt;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 1'b0;
      sel   <= 1'b0;
      gnt   <= 2'b00;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      sel   <= sel_n;
      gnt   <= (state_n == OWN1) ? 2'b10 : (state_n == OWN0) ? 2'b01 : 2'b00;
      busy  <= (state_n != IDLE);
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt_n;
      timeout  <= timeout_n;
    end
  end
`else
  // MAX_HOLD has no effect without the hold counter.
  assign timeout = 1'b0 & (MAX_HOLD < 1);
`endif

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed scoreboard bench for mux2_arbiter; expected {gnt,sel,busy,timeout} is queued per step.
module tb_mux2_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [1:0] last;
  logic [1:0] gnt;
  logic       sel;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  logic [4:0] sb[$];

  mux2_arbiter #(.MAX_HOLD(8)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .last(last),
    .gnt(gnt),
    .sel(sel),
    .busy(busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag);
    logic [4:0] exp_v;
    logic [4:0] obs_v;
    exp_v = sb.pop_front();
    obs_v = {gnt, sel, busy, timeout};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed gnt/sel/busy/timeout=%b expected %b", tag, obs_v, exp_v);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, sample 1ns after the edge.
  task automatic apply_stimulus(input logic [1:0] r, input logic [1:0] l,
                                input logic [1:0] eg, input logic es,
                                input logic eb, input logic et, input string tag);
    req  = r;
    last = l;
    sb.push_back({eg, es, eb, et});
    @(posedge clk);
    #1;
    check_output(tag);
  endtask

  initial begin
    reset = 1'b0;
    req   = 2'b00;
    last  = 2'b00;
    #1 reset = 1'b1;
    #1;
    sb.push_back(5'b00000);
    check_output("reset_state");
    @(posedge clk);
    #1 reset = 1'b0;

    // Both request after reset: ptr=0 wins, then last[0] hands off with no gap.
    apply_stimulus(2'b11, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, "both_req_ptr0");
    apply_stimulus(2'b11, 2'b01, 2'b10, 1'b1, 1'b1, 1'b0, "handoff_on_last0");

    // Requester 1 burst ends with last[1] while req[0]=0: idle, sel stays 1.
    apply_stimulus(2'b10, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, "burst1_beat");
    apply_stimulus(2'b10, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, "burst1_beat2");
    apply_stimulus(2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, "release1_to_idle");
    apply_stimulus(2'b11, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, "both_req_after_release1");

    // Non-owner last must not disturb owner 0.
    apply_stimulus(2'b11, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0, "stray_last_nonowner");
    apply_stimulus(2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, "owner0_hold");
    apply_stimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "drop_req0_to_idle");
    apply_stimulus(2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, "stray_last_idle");

    // ptr now points at requester 1.
    apply_stimulus(2'b11, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, "both_req_ptr1");
    apply_stimulus(2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, "release1_req_held");
    apply_stimulus(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, "idle_sel_hold");

    // Asynchronous reset in the middle of an OWN1 cycle.
    apply_stimulus(2'b10, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, "own1_before_reset");
    #2 reset = 1'b1;
    #1;
    sb.push_back(5'b00000);
    check_output("async_reset_mid_own1");
    #1 reset = 1'b0;
    apply_stimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "idle_after_reset");

    // Requester 0 holds without last; requester 1 joins on the third step.
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++)
      apply_stimulus((k >= 3) ? 2'b11 : 2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, "hold0_before_timeout");
    apply_stimulus(2'b11, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, "forced_handoff");
    apply_stimulus(2'b11, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, "timeout_single_pulse");
    apply_stimulus(2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, "release_after_timeout");
`else
    for (int k = 1; k <= 20; k++)
      apply_stimulus((k >= 3) ? 2'b11 : 2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, "hold0_no_timeout");
    apply_stimulus(2'b11, 2'b01, 2'b10, 1'b1, 1'b1, 1'b0, "handoff_after_long_hold");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
